// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words over Avalon-MM,
// compares them with build-time values and latches a pass/fail status.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1476153736,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int unsigned TW = 16;
    localparam int unsigned RW = 4;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t          state;
    logic [TW-1:0]   tcount;
    logic [RW-1:0]   retry;
    logic            auto_start;
    logic            accepted;
    logic            got_data;
    logic            timed_out;

    // Data counts in the accept cycle itself (zero-latency slave) or any WAIT cycle.
    assign accepted  = (state == S_REQ) && !avm_waitrequest;
    assign got_data  = avm_readdatavalid && (accepted || (state == S_WAIT));
    assign timed_out = (tcount == TLAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tcount      <= '0;
            retry       <= '0;
            auto_start  <= 1'b1;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            auto_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || auto_start) begin
                        avm_address <= 1'b0;
                        retry       <= '0;
                        tcount      <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    tcount <= tcount + TW'(1);
                    if (got_data) begin
                        if (avm_address) ts_value <= avm_readdata;
                        else             id_value <= avm_readdata;
                        avm_read <= 1'b0;
                        state    <= S_NEXT;
                    end else if (timed_out) begin
                        if (retry < RMAX) begin
                            retry    <= retry + RW'(1);
                            tcount   <= '0;
                            avm_read <= 1'b1;
                            state    <= S_REQ;
                        end else begin
                            // Done/pass are latched on entry so they show in the FINISH cycle.
                            timeout_err <= 1'b1;
                            avm_read    <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            pass        <= 1'b0;
                            state       <= S_FINISH;
                        end
                    end else if (accepted) begin
                        avm_read <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_NEXT: begin
                    if (!avm_address) begin
                        avm_address <= 1'b1;
                        retry       <= '0;
                        tcount      <= '0;
                        avm_read    <= 1'b1;
                        state       <= S_REQ;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= !timeout_err && (id_value == EXPECTED_ID)
                                 && (ts_value == EXPECTED_TIMESTAMP);
                        state <= S_FINISH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: a configurable Avalon slave model,
// a run-level reference model feeding a queue, and a monitor that checks each finished run.
module tb_sysid_boot_checker;

    localparam int unsigned TMO  = 8;
    localparam int unsigned MAXR = 2;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1476153736;

    logic        clock;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    sysid_boot_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TMO),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .timeout_err       (timeout_err),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        pass;
        logic        terr;
        int          reads0;
        int          reads1;
        int          done_edge;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          edges    = 0;

    // Per-word slave behaviour: stall cycles, response latency, dead slave, data.
    int          cfg_stall[2];
    int          cfg_lat[2];
    bit          cfg_dead[2];
    logic [31:0] cfg_data[2];

    // Reference state: last captured words survive across runs until reset.
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) edges = edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run-level model: each good word costs stall+1+latency+1 cycles, a dead word
    // costs (MAXR+1) full timeouts and ends the run.
    task automatic predict(input int e_edge);
        exp_t x;
        int   total;
        bit   stop;
        total    = 1;
        stop     = 0;
        x.reads0 = 0;
        x.reads1 = 0;
        x.terr   = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (!stop) begin
                if (cfg_dead[w]) begin
                    total += int'(MAXR + 1) * int'(TMO);
                    if (w == 0) x.reads0 = int'(MAXR) + 1;
                    else        x.reads1 = int'(MAXR) + 1;
                    x.terr = 1'b1;
                    stop   = 1;
                end else begin
                    total += cfg_stall[w] + cfg_lat[w] + 2;
                    if (w == 0) begin x.reads0 = 1; m_id = cfg_data[0]; end
                    else        begin x.reads1 = 1; m_ts = cfg_data[1]; end
                end
            end
        end
        total      += 1;
        x.id        = m_id;
        x.ts        = m_ts;
        x.pass      = !x.terr && (m_id == EXP_ID) && (m_ts == EXP_TS);
        x.done_edge = e_edge + total - 2;
        sb.push_back(x);
    endtask

    // Avalon slave model, driven 1 time unit after each rising edge.
    bit   in_req   = 0;
    int   st_left  = 0;
    int   lat_left = -1;
    logic p_addr   = 1'b0;

    task automatic slave_step();
        logic a;
        a = avm_address;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = $urandom;
        if (reset) begin
            in_req   = 0;
            lat_left = -1;
        end else begin
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = cfg_data[p_addr];
                    lat_left          = -1;
                end
            end
            if (avm_read) begin
                if (!in_req) begin
                    in_req  = 1;
                    st_left = cfg_stall[a];
                end
                if (st_left > 0) begin
                    avm_waitrequest = 1'b1;
                    st_left--;
                end else begin
                    in_req = 0;
                    if (!cfg_dead[a]) begin
                        if (cfg_lat[a] == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = cfg_data[a];
                        end else begin
                            lat_left = cfg_lat[a];
                            p_addr   = a;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(posedge clock);
            #1;
            slave_step();
        end
    end

    // Monitor: counts accepted reads, checks stall stability, scores each done rise.
    int   n0 = 0;
    int   n1 = 0;
    logic prev_done  = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            n0 = 0;
            n1 = 0;
            prev_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("read_held_in_stall", 32'(avm_read), 32'd1);
                chk("addr_stable_in_stall", 32'(avm_address), 32'(prev_addr));
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (avm_read && !avm_waitrequest) begin
                if (avm_address) n1++;
                else             n0++;
            end
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("done_cycle", 32'(edges), 32'(x.done_edge));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("id_value", id_value, x.id);
                    chk("ts_value", ts_value, x.ts);
                    chk("pass", 32'(pass), 32'(x.pass));
                    chk("timeout_err", 32'(timeout_err), 32'(x.terr));
                    chk("reads_addr0", 32'(n0), 32'(x.reads0));
                    chk("reads_addr1", 32'(n1), 32'(x.reads1));
                end
                n0 = 0;
                n1 = 0;
            end
            prev_done = done;
        end
    end

    task automatic set_word(input int w, input int s, input int l, input bit dead,
                            input logic [31:0] d);
        cfg_stall[w] = s;
        cfg_lat[w]   = l;
        cfg_dead[w]  = dead;
        cfg_data[w]  = d;
    endtask

    task automatic do_start();
        @(posedge clock);
        #1;
        predict(edges + 1);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (sb.size() == 0) ok = 1;
        end
        if (!ok) begin
            chk("run_completes", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Asserts reset immediately, checks outputs asynchronously, then releases on a cycle boundary.
    task automatic reset_now();
        reset = 1'b1;
        sb.delete();
        m_id = '0;
        m_ts = '0;
        #1;
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_avm_address", 32'(avm_address), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        predict(edges + 1);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] bad_value(input logic [31:0] good);
        logic [31:0] v;
        v = $urandom;
        if (v == good) v = v ^ 32'h1;
        return v;
    endfunction

    initial begin
        bit found;
        reset = 1'b0;
        start = 1'b0;
        set_word(0, 0, 0, 0, EXP_ID);
        set_word(1, 0, 0, 0, EXP_TS);
        #2;
        reset_now();
        wait_done();

        // Timestamp off by one.
        set_word(1, 0, 0, 0, EXP_TS + 32'd1);
        do_start();
        wait_done();

        // Four stall cycles and three-cycle latency: lands exactly on the timeout limit.
        set_word(0, 4, 3, 0, EXP_ID);
        set_word(1, 4, 3, 0, EXP_TS);
        do_start();
        wait_done();

        // Dead slave on the ID word, then on the timestamp word.
        set_word(0, 0, 0, 1, EXP_ID);
        do_start();
        wait_done();
        set_word(0, 1, 2, 0, EXP_ID);
        set_word(1, 2, 0, 1, EXP_TS);
        do_start();
        wait_done();

        // Reset while waiting on the timestamp read, then automatic restart.
        set_word(0, 0, 0, 0, EXP_ID);
        set_word(1, 0, 6, 0, EXP_TS);
        do_start();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (busy && avm_address && !avm_read) found = 1;
        end
        chk("reached_wait_addr1", 32'(found), 32'd1);
        reset_now();
        wait_done();

        // Start while busy is ignored.
        set_word(0, 2, 2, 0, EXP_ID);
        set_word(1, 1, 3, 0, EXP_TS);
        do_start();
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_set", 32'(busy), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done();

        // Start coincident with the FINISH cycle is ignored.
        set_word(0, 0, 0, 0, EXP_ID);
        set_word(1, 0, 0, 0, EXP_TS);
        do_start();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (done) found = 1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        chk("finish_reached", 32'(found), 32'd1);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("finish_start_busy", 32'(busy), 32'd0);
        chk("finish_start_done", 32'(done), 32'd1);
        chk("finish_start_read", 32'(avm_read), 32'd0);
        wait_done();

        // Randomised runs.
        for (int r = 0; r < 24; r++) begin
            for (int w = 0; w < 2; w++) begin
                int s;
                int l;
                logic [31:0] good;
                good = (w == 0) ? EXP_ID : EXP_TS;
                s = int'($urandom_range(0, 4));
                l = int'($urandom_range(0, TMO - 1 - s));
                set_word(w, s, l, ($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 3) != 0) ? good : bad_value(good));
            end
            do_start();
            wait_done();
        end

        repeat (4) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
